// File: rtl/mul_seq_iter.sv
// Iterative shift-add multiplier, signed or unsigned, one bit per clock.
// Optional MUL_EARLY_TERM_EN: leave CALC once the multiplier register is zero.
module mul_seq_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               Signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] Prod
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   mplier_nxt;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [CW-1:0]      cnt;
  logic               sign_p;
  logic               last;
  logic               accept;

  // Operand magnitudes and the next partial-product step
  always_comb begin
    a_mag      = (Signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
    b_mag      = (Signed && B[WIDTH-1]) ? (~B + 1'b1) : B;
    acc_nxt    = mplier[0] ? (acc + mcand) : acc;
    mplier_nxt = mplier >> 1;
`ifdef MUL_EARLY_TERM_EN
    last       = (mplier_nxt == '0);
`else
    last       = (cnt == CW'(WIDTH - 1));
`endif
    accept     = (state == IDLE) && in_valid;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture, shift-add iterations, signed result fix-up
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      sign_p <= 1'b0;
      Prod   <= '0;
    end else if (accept) begin
      mcand  <= {{WIDTH{1'b0}}, a_mag};
      mplier <= b_mag;
      acc    <= '0;
      cnt    <= '0;
      sign_p <= Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
    end else if (state == CALC) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier_nxt;
      cnt    <= cnt + CW'(1);
      if (last) Prod <= sign_p ? (~acc_nxt + 1'b1) : acc_nxt;
    end
  end

endmodule

// File: tb/tb_mul_seq_iter.sv
// Directed self-checking bench for mul_seq_iter (WIDTH=8 and WIDTH=16).
// Latency expectations follow MUL_EARLY_TERM_EN when it is defined.
`ifdef MUL_EARLY_TERM_EN
`define LAT(e) (e)
`define LAT16 2
`else
`define LAT(e) 8
`define LAT16 16
`endif
module tb_mul_seq_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        sgn;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] prod;

  logic        in_valid16;
  logic        in_ready16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        sgn16;
  logic        out_valid16;
  logic        out_ready16;
  logic [31:0] prod16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_seq_iter #(.WIDTH(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .Signed    (sgn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Prod      (prod)
  );

  mul_seq_iter #(.WIDTH(16)) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .A         (a16),
    .B         (b16),
    .Signed    (sgn16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .Prod      (prod16)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] av,
                        input logic [7:0] bv, input logic sv,
                        input logic [15:0] exp, input int lat);
    int n;
    @(negedge clk);
    a = av;
    b = bv;
    sgn = sv;
    in_valid = 1'b1;
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(lat));
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " prod"}, 32'(prod), 32'(exp));
  endtask

  task automatic finish_op(input string tag);
    @(posedge clk);
    #1;
    chk({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    chk({tag, " in_ready back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0]  va [3];
    logic [7:0]  vb [3];
    logic [15:0] vp [3];
    int          tt [3];
    int          n;
    int          k;
    int          r;
    int          cyc;
    int          seen;
    logic [15:0] held;

    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    sgn = 1'b0;
    out_ready = 1'b1;
    in_valid16 = 1'b0;
    a16 = '0;
    b16 = '0;
    sgn16 = 1'b0;
    out_ready16 = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset prod", 32'(prod), 32'd0);
    @(negedge clk) rst = 1'b0;

    // abort mid-CALC with an asynchronous reset pulse
    @(negedge clk);
    a = 8'd200;
    b = 8'd3;
    sgn = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("midcalc in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort no result", 32'(seen), 32'd0);
    chk("abort prod", 32'(prod), 32'd0);

    run_op("u255x255", 8'd255, 8'd255, 1'b0, 16'hFE01, `LAT(8));
    finish_op("u255x255");
    run_op("u200x3", 8'd200, 8'd3, 1'b0, 16'h0258, `LAT(2));
    finish_op("u200x3");
    run_op("s80x80", 8'h80, 8'h80, 1'b1, 16'h4000, `LAT(8));
    finish_op("s80x80");
    run_op("s80x01", 8'h80, 8'h01, 1'b1, 16'hFF80, `LAT(1));
    finish_op("s80x01");
    run_op("sFDx05", 8'hFD, 8'd5, 1'b1, 16'hFFF1, `LAT(3));
    finish_op("sFDx05");
    run_op("s7Fx80", 8'h7F, 8'h80, 1'b1, 16'hC080, `LAT(8));
    finish_op("s7Fx80");
    run_op("u80x80", 8'h80, 8'h80, 1'b0, 16'h4000, `LAT(8));
    finish_op("u80x80");
    run_op("s85x00", 8'h85, 8'h00, 1'b1, 16'h0000, `LAT(1));
    finish_op("s85x00");
    run_op("s00xFF", 8'h00, 8'hFF, 1'b1, 16'h0000, `LAT(1));
    finish_op("s00xFF");

    // backpressure: result held, new operands ignored
    out_ready = 1'b0;
    run_op("bp", 8'd12, 8'd13, 1'b0, 16'd156, `LAT(4));
    held = prod;
    repeat (10) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 8'h11;
      b = 8'h22;
      chk("bp out_valid", 32'(out_valid), 32'd1);
      chk("bp in_ready", 32'(in_ready), 32'd0);
      chk("bp prod", 32'(prod), 32'(held));
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    finish_op("bp");
    repeat (3) @(negedge clk);
    chk("bp retained prod", 32'(prod), 32'd156);
    chk("bp idle out_valid", 32'(out_valid), 32'd0);

    // back-to-back with in_valid held
    va[0] = 8'h12; vb[0] = 8'h90; vp[0] = 16'h0A20;
    va[1] = 8'h0F; vb[1] = 8'hF0; vp[1] = 16'h0E10;
    va[2] = 8'hFF; vb[2] = 8'h80; vp[2] = 16'h7F80;
    sgn = 1'b0;
    k = 0;
    r = 0;
    cyc = 0;
    while (r < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        chk("b2b prod", 32'(prod), 32'(vp[r]));
        tt[r] = cyc;
        r++;
      end
      if (in_ready) begin
        if (k < 3) begin
          a = va[k];
          b = vb[k];
          in_valid = 1'b1;
          k++;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    chk("b2b results", 32'(r), 32'd3);
    chk("b2b spacing01", 32'(tt[1] - tt[0]), 32'd10);
    chk("b2b spacing12", 32'(tt[2] - tt[1]), 32'd10);

    // WIDTH=16 signed run
    @(negedge clk);
    a16 = 16'hFFFF;
    b16 = 16'h0002;
    sgn16 = 1'b1;
    in_valid16 = 1'b1;
    @(posedge clk);
    #1 in_valid16 = 1'b0;
    n = 0;
    while (!out_valid16 && n < 60) begin
      @(posedge clk);
      #1 n++;
    end
    chk("w16 latency", 32'(n), 32'(`LAT16));
    chk("w16 prod", prod16, 32'hFFFFFFFE);
    @(posedge clk);
    #1;
    chk("w16 in_ready", 32'(in_ready16), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
